// File: rtl/pipeline_pkg.sv
// Shared pipeline types: writeback source select, load funct3 codes, MEM/WB register layout.
// Imported by the writeback stage, its load extender and the bench.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    wb_sel_e     wb_sel;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] ld_data;
  } memwb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage inputs, pipeline control and regfile write port of the writeback stage.
// o_instret exists only when WB_INSTRET_EN is defined.
interface writeback_stage_if;

  logic        i_stall;
  logic        i_flush;
  logic        i_valid;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wren;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result;
  logic [31:0] i_pc_plus4;
  logic [31:0] i_ld_data;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;
  logic        o_wb_valid;
`ifdef WB_INSTRET_EN
  logic [63:0] o_instret;

  modport master (
    output i_stall, i_flush, i_valid, i_rd_addr, i_rd_wren, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_ld_data,
    input  o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid, o_instret
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_rd_addr, i_rd_wren, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_ld_data,
    output o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid, o_instret
  );
`else
  modport master (
    output i_stall, i_flush, i_valid, i_rd_addr, i_rd_wren, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_ld_data,
    input  o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_rd_addr, i_rd_wren, i_wb_sel, i_funct3,
           i_alu_result, i_pc_plus4, i_ld_data,
    output o_rd_addr, o_rd_data, o_rd_wren, o_wb_valid
  );
`endif

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Combinational load extraction: picks byte/half/word at the address offset and sign/zero extends.
// Zero latency, no state; shared with the MEM stage.
module load_extend
  import pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // offset[0] is ignored for halves: misaligned halves trap before reaching here
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = word;
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register plus writeback mux driving the regfile write port; one cycle MEM->WB, stall holds, flush bubbles.
// Optional retired-instruction counter o_instret under WB_INSTRET_EN.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  writeback_stage_if.slave wb
);

  memwb_t          r;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] src_data;
  logic            wren;

  always_ff @(posedge i_clk) begin
    if (i_reset || wb.i_flush) begin
      r <= '0;
    end else if (!wb.i_stall) begin
      r.valid      <= wb.i_valid;
      r.rd_wren    <= wb.i_rd_wren;
      r.rd_addr    <= wb.i_rd_addr;
      r.wb_sel     <= wb_sel_e'(wb.i_wb_sel);
      r.funct3     <= wb.i_funct3;
      r.alu_result <= wb.i_alu_result;
      r.pc_plus4   <= wb.i_pc_plus4;
      r.ld_data    <= wb.i_ld_data;
    end
  end

  load_extend u_load_extend (
    .funct3 (r.funct3),
    .offset (r.alu_result[1:0]),
    .word   (r.ld_data),
    .result (ld_ext)
  );

  always_comb begin
    src_data = '0;
    case (r.wb_sel)
      WB_ALU:  src_data = r.alu_result;
      WB_LOAD: src_data = ld_ext;
      WB_PC4:  src_data = r.pc_plus4;
      default: src_data = '0;
    endcase
  end

  // Bubbles, x0 and the reserved select never reach the regfile
  assign wren = r.valid && r.rd_wren && (r.rd_addr != 5'd0) && (r.wb_sel != WB_RSVD);

  assign wb.o_rd_addr  = r.rd_addr;
  assign wb.o_rd_wren  = wren;
  assign wb.o_rd_data  = wren ? src_data : '0;
  assign wb.o_wb_valid = r.valid;

`ifdef WB_INSTRET_EN
  logic [63:0] instret;

  // A stalled instruction is counted once, on the edge it leaves the register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instret <= '0;
    end else if (r.valid && !wb.i_stall) begin
      instret <= instret + 64'd1;
    end
  end

  assign wb.o_instret = instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, ALU/load/PC+4 writeback, x0, reserved select, stall/flush.
// Counter checks compile in only with WB_INSTRET_EN.
module tb_writeback_stage;
  import pipeline_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  writeback_stage_if wbif ();

  writeback_stage #(.XLEN(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .wb      (wbif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld);
    wbif.i_valid      = v;
    wbif.i_rd_addr    = rd;
    wbif.i_rd_wren    = we;
    wbif.i_wb_sel     = sel;
    wbif.i_funct3     = f3;
    wbif.i_alu_result = alu;
    wbif.i_pc_plus4   = pc4;
    wbif.i_ld_data    = ld;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
    string       tag;
  } ld_vec_t;

  ld_vec_t ld_vecs[6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    ld_vecs[0] = '{F3_LB,  2'd3, 32'hFFFF_FF80, "lb_off3"};
    ld_vecs[1] = '{F3_LBU, 2'd3, 32'h0000_0080, "lbu_off3"};
    ld_vecs[2] = '{F3_LB,  2'd1, 32'h0000_007F, "lb_off1"};
    ld_vecs[3] = '{F3_LH,  2'd2, 32'hFFFF_80FF, "lh_off2"};
    ld_vecs[4] = '{F3_LHU, 2'd0, 32'h0000_7F01, "lhu_off0"};
    ld_vecs[5] = '{F3_LW,  2'd0, 32'h80FF_7F01, "lw_off0"};

    // Reset held two cycles with a valid write presented
    rst = 1'b1;
    wbif.i_stall = 1'b0;
    wbif.i_flush = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_wren",  {63'h0, wbif.o_rd_wren},  64'h0);
      chk("rst_data",  {32'h0, wbif.o_rd_data},  64'h0);
      chk("rst_valid", {63'h0, wbif.o_wb_valid}, 64'h0);
    end
    chk("rst_addr", {59'h0, wbif.o_rd_addr}, 64'h0);
    rst = 1'b0;

    // ALU writeback
    drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
    tick();
    chk("alu_addr",  {59'h0, wbif.o_rd_addr}, 64'd5);
    chk("alu_wren",  {63'h0, wbif.o_rd_wren}, 64'd1);
    chk("alu_data",  {32'h0, wbif.o_rd_data}, 64'h1234_5678);
    chk("alu_valid", {63'h0, wbif.o_wb_valid}, 64'd1);

    // Load extraction
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd9, 1'b1, 2'b01, ld_vecs[i].f3, {30'h1000, ld_vecs[i].off}, 32'h0, 32'h80FF_7F01);
      tick();
      chk(ld_vecs[i].tag, {32'h0, wbif.o_rd_data}, {32'h0, ld_vecs[i].exp});
    end

    // x0 destination
    drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'hAAAA_5555, 32'h0, 32'h0);
    tick();
    chk("x0_wren", {63'h0, wbif.o_rd_wren}, 64'h0);
    chk("x0_data", {32'h0, wbif.o_rd_data}, 64'h0);

    // Reserved select
    drive(1'b1, 5'd7, 1'b1, 2'b11, 3'b000, 32'hAAAA_5555, 32'h8, 32'h0);
    tick();
    chk("rsvd_wren", {63'h0, wbif.o_rd_wren}, 64'h0);
    chk("rsvd_data", {32'h0, wbif.o_rd_data}, 64'h0);
    chk("rsvd_addr", {59'h0, wbif.o_rd_addr}, 64'd7);

    // Instruction with wren=0
    drive(1'b1, 5'd3, 1'b0, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0);
    tick();
    chk("nowren_wren", {63'h0, wbif.o_rd_wren}, 64'h0);

    // JAL captured then stalled three cycles; changing inputs must not leak through
    drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0000_0200, 32'h0000_0104, 32'h0);
    tick();
    chk("jal_data0", {32'h0, wbif.o_rd_data}, 64'h0000_0104);
    wbif.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd12, 1'b1, 2'b00, 3'b000, 32'h1111_0000 + i, 32'h0, 32'h0);
      tick();
      chk("stall_data", {32'h0, wbif.o_rd_data}, 64'h0000_0104);
      chk("stall_addr", {59'h0, wbif.o_rd_addr}, 64'd1);
    end
    wbif.i_flush = 1'b1;
    tick();
    chk("flush_valid", {63'h0, wbif.o_wb_valid}, 64'h0);
    chk("flush_wren",  {63'h0, wbif.o_rd_wren},  64'h0);
    wbif.i_flush = 1'b0;
    wbif.i_stall = 1'b0;

    // Reset in mid-stream discards the in-flight instruction
    drive(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0);
    tick();
    chk("pre_rst_wren", {63'h0, wbif.o_rd_wren}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_wren",  {63'h0, wbif.o_rd_wren},  64'h0);
    chk("mid_rst_valid", {63'h0, wbif.o_wb_valid}, 64'h0);
    rst = 1'b0;

`ifdef WB_INSTRET_EN
    begin
      string sched;
      sched = "IISIISSIFIIFIII";
      chk("instret_rst", wbif.o_instret, 64'h0);
      for (int i = 0; i < sched.len(); i++) begin
        wbif.i_stall = (sched[i] == "S");
        wbif.i_flush = (sched[i] == "F");
        drive(sched[i] == "I", 5'd2, 1'b1, 2'b00, 3'b000, i, 32'h0, 32'h0);
        tick();
      end
      wbif.i_stall = 1'b0;
      wbif.i_flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
      tick();
      tick();
      chk("instret_cnt", wbif.o_instret, 64'd10);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
